// File: rtl/stage_ex.sv
// Execute stage of the 5-stage MIPS pipeline.
// Holds the combinational ALU, the single-cycle multiplier, HI/LO write
// generation and a sequential restoring divider that stalls the pipe
// while it works. Every output is held at zero while reset is high.
module stage_ex #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cancel,
  input  logic [31:0] instruction_i,
  input  logic [7:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        register_write_enable_i,
  input  logic [4:0]  register_write_address_i,
  input  logic [31:0] register_hi_i,
  input  logic [31:0] register_lo_i,
  output logic [31:0] instruction_o,
  output logic [7:0]  operator_o,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  output logic        register_write_enable_o,
  output logic [4:0]  register_write_address_o,
  output logic [31:0] register_write_data_o,
  output logic        register_hi_write_enable_o,
  output logic [31:0] register_hi_write_data_o,
  output logic        register_lo_write_enable_o,
  output logic [31:0] register_lo_write_data_o,
  output logic        stall_request
);

  // Operator codes shared with the decode stage.
  localparam logic [7:0] OPERATOR_NOP   = 8'h00;
  localparam logic [7:0] OPERATOR_SRL   = 8'h02;
  localparam logic [7:0] OPERATOR_SRA   = 8'h03;
  localparam logic [7:0] OPERATOR_MFHI  = 8'h10;
  localparam logic [7:0] OPERATOR_MTHI  = 8'h11;
  localparam logic [7:0] OPERATOR_MFLO  = 8'h12;
  localparam logic [7:0] OPERATOR_MTLO  = 8'h13;
  localparam logic [7:0] OPERATOR_MULT  = 8'h18;
  localparam logic [7:0] OPERATOR_MULTU = 8'h19;
  localparam logic [7:0] OPERATOR_DIV   = 8'h1A;
  localparam logic [7:0] OPERATOR_DIVU  = 8'h1B;
  localparam logic [7:0] OPERATOR_ADDU  = 8'h21;
  localparam logic [7:0] OPERATOR_SUBU  = 8'h23;
  localparam logic [7:0] OPERATOR_AND   = 8'h24;
  localparam logic [7:0] OPERATOR_OR    = 8'h25;
  localparam logic [7:0] OPERATOR_XOR   = 8'h26;
  localparam logic [7:0] OPERATOR_NOR   = 8'h27;
  localparam logic [7:0] OPERATOR_SLT   = 8'h2A;
  localparam logic [7:0] OPERATOR_SLTU  = 8'h2B;
  localparam logic [7:0] OPERATOR_LUI   = 8'h5C;
  localparam logic [7:0] OPERATOR_SLL   = 8'h7C;

  localparam logic [4:0] LAST_STEP = 5'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  div_state_t  state_r;
  div_state_t  state_next_s;
  logic [4:0]  count_r;
  // Dividend register doubles as the quotient: quotient bits enter at the LSB.
  logic [31:0] dividend_r;
  logic [31:0] divisor_r;
  logic [31:0] remainder_r;
  logic        quotient_neg_r;
  logic        remainder_neg_r;

  logic        is_div_s;
  logic        is_signed_div_s;
  logic        sign_a_s;
  logic        sign_b_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic        divisor_zero_s;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;
  logic        div_done_s;
  logic        stall_s;
  logic [31:0] quotient_fix_s;
  logic [31:0] remainder_fix_s;

  logic [4:0]         shamt_s;
  logic signed [31:0] sra_s;
  logic [63:0]        product_signed_s;
  logic [63:0]        product_unsigned_s;

  logic        wen_s;
  logic [31:0] wdata_s;
  logic        hi_we_s;
  logic [31:0] hi_wd_s;
  logic        lo_we_s;
  logic [31:0] lo_wd_s;

  // Divider operand conditioning: magnitudes for DIV, raw values for DIVU.
  always_comb begin
    is_div_s        = (operator_i == OPERATOR_DIV) || (operator_i == OPERATOR_DIVU);
    is_signed_div_s = (operator_i == OPERATOR_DIV);
    sign_a_s        = is_signed_div_s & operand_a_i[31];
    sign_b_s        = is_signed_div_s & operand_b_i[31];
    abs_a_s         = sign_a_s ? (32'd0 - operand_a_i) : operand_a_i;
    abs_b_s         = sign_b_s ? (32'd0 - operand_b_i) : operand_b_i;
    divisor_zero_s  = (operand_b_i == 32'd0);
    // One restoring step: a borrow out of the 33-bit trial subtract means keep
    // the shifted remainder and record a 0 quotient bit.
    shifted_s       = {remainder_r, dividend_r[31]};
    diff_s          = shifted_s - {1'b0, divisor_r};
    quotient_fix_s  = quotient_neg_r ? (32'd0 - dividend_r) : dividend_r;
    remainder_fix_s = remainder_neg_r ? (32'd0 - remainder_r) : remainder_r;
  end

  // Divider next-state, stall and completion; cancel always wins.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    div_done_s   = 1'b0;
    case (state_r)
      DIV_IDLE: begin
        if (cancel) begin
          state_next_s = DIV_IDLE;
        end else if (is_div_s) begin
          stall_s      = 1'b1;
          state_next_s = divisor_zero_s ? DIV_DONE : DIV_BUSY;
        end else begin
          state_next_s = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (cancel) begin
          state_next_s = DIV_IDLE;
        end else begin
          stall_s      = 1'b1;
          state_next_s = (count_r == LAST_STEP) ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_DONE: begin
        if (cancel) begin
          state_next_s = DIV_IDLE;
        end else begin
          div_done_s   = 1'b1;
          state_next_s = DIV_IDLE;
        end
      end
      default: begin
        state_next_s = DIV_IDLE;
      end
    endcase
  end

  // Divider state and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r         <= DIV_IDLE;
      count_r         <= 5'd0;
      dividend_r      <= 32'd0;
      divisor_r       <= 32'd0;
      remainder_r     <= 32'd0;
      quotient_neg_r  <= 1'b0;
      remainder_neg_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        DIV_IDLE: begin
          if (!cancel && is_div_s) begin
            count_r <= 5'd0;
            if (divisor_zero_s) begin
              dividend_r      <= 32'hFFFF_FFFF;
              divisor_r       <= 32'd0;
              remainder_r     <= operand_a_i;
              quotient_neg_r  <= 1'b0;
              remainder_neg_r <= 1'b0;
            end else begin
              dividend_r      <= abs_a_s;
              divisor_r       <= abs_b_s;
              remainder_r     <= 32'd0;
              quotient_neg_r  <= sign_a_s ^ sign_b_s;
              remainder_neg_r <= sign_a_s;
            end
          end
        end
        DIV_BUSY: begin
          if (!cancel) begin
            remainder_r <= diff_s[32] ? shifted_s[31:0] : diff_s[31:0];
            dividend_r  <= {dividend_r[30:0], ~diff_s[32]};
            count_r     <= count_r + 5'd1;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Shifter and multiplier operands.
  always_comb begin
    shamt_s            = instruction_i[10:6];
    sra_s              = $signed(operand_b_i) >>> shamt_s;
    product_signed_s   = $signed({{32{operand_a_i[31]}}, operand_a_i})
                       * $signed({{32{operand_b_i[31]}}, operand_b_i});
    product_unsigned_s = {32'd0, operand_a_i} * {32'd0, operand_b_i};
  end

  // ALU result, GPR enable and HI/LO write selection.
  always_comb begin
    wen_s   = register_write_enable_i;
    wdata_s = 32'd0;
    hi_we_s = 1'b0;
    hi_wd_s = 32'd0;
    lo_we_s = 1'b0;
    lo_wd_s = 32'd0;
    case (operator_i)
      OPERATOR_ADDU: wdata_s = operand_a_i + operand_b_i;
      OPERATOR_SUBU: wdata_s = operand_a_i - operand_b_i;
      OPERATOR_AND:  wdata_s = operand_a_i & operand_b_i;
      OPERATOR_OR:   wdata_s = operand_a_i | operand_b_i;
      OPERATOR_XOR:  wdata_s = operand_a_i ^ operand_b_i;
      OPERATOR_NOR:  wdata_s = ~(operand_a_i | operand_b_i);
      OPERATOR_SLL:  wdata_s = operand_b_i << shamt_s;
      OPERATOR_SRL:  wdata_s = operand_b_i >> shamt_s;
      OPERATOR_SRA:  wdata_s = sra_s;
      OPERATOR_SLT:  wdata_s = {31'd0, ($signed(operand_a_i) < $signed(operand_b_i))};
      OPERATOR_SLTU: wdata_s = {31'd0, (operand_a_i < operand_b_i)};
      OPERATOR_LUI:  wdata_s = {operand_b_i[15:0], 16'd0};
      OPERATOR_MFHI: wdata_s = register_hi_i;
      OPERATOR_MFLO: wdata_s = register_lo_i;
      OPERATOR_MTHI: begin
        wen_s   = 1'b0;
        hi_we_s = 1'b1;
        hi_wd_s = operand_a_i;
      end
      OPERATOR_MTLO: begin
        wen_s   = 1'b0;
        lo_we_s = 1'b1;
        lo_wd_s = operand_a_i;
      end
      OPERATOR_MULT: begin
        hi_we_s = 1'b1;
        hi_wd_s = product_signed_s[63:32];
        lo_we_s = 1'b1;
        lo_wd_s = product_signed_s[31:0];
      end
      OPERATOR_MULTU: begin
        hi_we_s = 1'b1;
        hi_wd_s = product_unsigned_s[63:32];
        lo_we_s = 1'b1;
        lo_wd_s = product_unsigned_s[31:0];
      end
      OPERATOR_NOP:  wdata_s = 32'd0;
      default:       wdata_s = 32'd0;
    endcase
    // Divider completion owns HI/LO for its single DONE cycle.
    if (div_done_s) begin
      hi_we_s = 1'b1;
      hi_wd_s = remainder_fix_s;
      lo_we_s = 1'b1;
      lo_wd_s = quotient_fix_s;
    end else begin
      hi_we_s = hi_we_s;
    end
  end

  // Output drive, forced to zero while reset is asserted.
  always_comb begin
    if (reset) begin
      instruction_o              = 32'd0;
      operator_o                 = 8'd0;
      operand_a_o                = 32'd0;
      operand_b_o                = 32'd0;
      register_write_enable_o    = 1'b0;
      register_write_address_o   = 5'd0;
      register_write_data_o      = 32'd0;
      register_hi_write_enable_o = 1'b0;
      register_hi_write_data_o   = 32'd0;
      register_lo_write_enable_o = 1'b0;
      register_lo_write_data_o   = 32'd0;
      stall_request              = 1'b0;
    end else begin
      instruction_o              = instruction_i;
      operator_o                 = operator_i;
      operand_a_o                = operand_a_i;
      operand_b_o                = operand_b_i;
      register_write_enable_o    = wen_s;
      register_write_address_o   = register_write_address_i;
      register_write_data_o      = wdata_s;
      register_hi_write_enable_o = hi_we_s;
      register_hi_write_data_o   = hi_wd_s;
      register_lo_write_enable_o = lo_we_s;
      register_lo_write_data_o   = lo_wd_s;
      stall_request              = stall_s;
    end
  end

endmodule

// File: tb/tb_stage_ex.sv
// Directed testbench for stage_ex: ALU ops, MULT, divider latency,
// divide-by-zero, cancel and reset abort.
module tb_stage_ex;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLT   = 8'h2A;
  localparam logic [7:0] OP_SLTU  = 8'h2B;
  localparam logic [7:0] OP_LUI   = 8'h5C;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_LW    = 8'hE3;

  logic        clock;
  logic        reset;
  logic        cancel;
  logic [31:0] instruction_i;
  logic [7:0]  operator_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        register_write_enable_i;
  logic [4:0]  register_write_address_i;
  logic [31:0] register_hi_i;
  logic [31:0] register_lo_i;
  logic [31:0] instruction_o;
  logic [7:0]  operator_o;
  logic [31:0] operand_a_o;
  logic [31:0] operand_b_o;
  logic        register_write_enable_o;
  logic [4:0]  register_write_address_o;
  logic [31:0] register_write_data_o;
  logic        register_hi_write_enable_o;
  logic [31:0] register_hi_write_data_o;
  logic        register_lo_write_enable_o;
  logic [31:0] register_lo_write_data_o;
  logic        stall_request;

  int checks_total;
  int errors;

  stage_ex dut (
    .clock                      (clock),
    .reset                      (reset),
    .cancel                     (cancel),
    .instruction_i              (instruction_i),
    .operator_i                 (operator_i),
    .operand_a_i                (operand_a_i),
    .operand_b_i                (operand_b_i),
    .register_write_enable_i    (register_write_enable_i),
    .register_write_address_i   (register_write_address_i),
    .register_hi_i              (register_hi_i),
    .register_lo_i              (register_lo_i),
    .instruction_o              (instruction_o),
    .operator_o                 (operator_o),
    .operand_a_o                (operand_a_o),
    .operand_b_o                (operand_b_o),
    .register_write_enable_o    (register_write_enable_o),
    .register_write_address_o   (register_write_address_o),
    .register_write_data_o      (register_write_data_o),
    .register_hi_write_enable_o (register_hi_write_enable_o),
    .register_hi_write_data_o   (register_hi_write_data_o),
    .register_lo_write_enable_o (register_lo_write_enable_o),
    .register_lo_write_data_o   (register_lo_write_data_o),
    .stall_request              (stall_request)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sa);
    operator_i    = op;
    operand_a_i   = a;
    operand_b_i   = b;
    instruction_i = {21'd0, sa, 6'd0};
  endtask

  // Issue a divide just after a rising edge, count stall cycles, check the
  // single HI/LO write cycle and that it is not repeated.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stalls,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int  stalls;
    bit  done;
    bit  early_write;
    stalls      = 0;
    done        = 1'b0;
    early_write = 1'b0;
    @(posedge clock); #1;
    drive(op, a, b, 5'd0);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clock);
      if (stall_request) begin
        stalls++;
        if (register_hi_write_enable_o || register_lo_write_enable_o) early_write = 1'b1;
      end else begin
        done = 1'b1;
        break;
      end
    end
    check_value({tag, "_finished"}, 64'(done), 64'd1);
    check_value({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    check_value({tag, "_no_early_write"}, 64'(early_write), 64'd0);
    check_value({tag, "_we"}, {62'd0, register_hi_write_enable_o, register_lo_write_enable_o}, 64'd3);
    check_value({tag, "_lo"}, 64'(register_lo_write_data_o), 64'(exp_lo));
    check_value({tag, "_hi"}, 64'(register_hi_write_data_o), 64'(exp_hi));
    operator_i = OP_NOP;
    @(negedge clock);
    check_value({tag, "_one_shot"},
                {61'd0, register_hi_write_enable_o, register_lo_write_enable_o, stall_request}, 64'd0);
  endtask

  typedef struct {
    string       tag;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t alu_vecs[14];
  bit       flag;

  initial begin
    checks_total = 0;
    errors       = 0;
    flag         = 1'b0;
    alu_vecs[0]  = '{"subu", OP_SUBU, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE};
    alu_vecs[1]  = '{"and",  OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200};
    alu_vecs[2]  = '{"or",   OP_OR,   32'hF000_0001, 32'h0000_00F0, 5'd0, 32'hF000_00F1};
    alu_vecs[3]  = '{"xor",  OP_XOR,  32'hFFFF_0000, 32'hF0F0_F0F0, 5'd0, 32'h0F0F_F0F0};
    alu_vecs[4]  = '{"nor",  OP_NOR,  32'hFFFF_0000, 32'h0000_00FF, 5'd0, 32'h0000_FF00};
    alu_vecs[5]  = '{"sll",  OP_SLL,  32'd0, 32'h8000_0001, 5'd4, 32'h0000_0010};
    alu_vecs[6]  = '{"srl",  OP_SRL,  32'd0, 32'hF000_0000, 5'd4, 32'h0F00_0000};
    alu_vecs[7]  = '{"sra",  OP_SRA,  32'd0, 32'hF000_0000, 5'd4, 32'hFF00_0000};
    alu_vecs[8]  = '{"slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1};
    alu_vecs[9]  = '{"sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0};
    alu_vecs[10] = '{"lui",  OP_LUI,  32'd0, 32'h1234_ABCD, 5'd0, 32'hABCD_0000};
    alu_vecs[11] = '{"mfhi", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'hAAAA_5555};
    alu_vecs[12] = '{"mflo", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'h1357_9BDF};
    alu_vecs[13] = '{"addu_wrap", OP_ADDU, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1};

    reset                    = 1'b1;
    cancel                   = 1'b0;
    register_write_enable_i  = 1'b1;
    register_write_address_i = 5'd9;
    register_hi_i            = 32'hAAAA_5555;
    register_lo_i            = 32'h1357_9BDF;
    drive(OP_NOP, 32'd0, 32'd0, 5'd0);

    @(negedge clock);
    check_value("reset_stall", 64'(stall_request), 64'd0);
    reset = 1'b0;

    // Start a divide, then hit reset while it is busy.
    @(posedge clock); #1;
    drive(OP_DIVU, 32'd100, 32'd7, 5'd0);
    @(negedge clock);
    check_value("pre_reset_div_stall", 64'(stall_request), 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    drive(OP_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0);
    instruction_i = 32'h1234_5678;
    @(negedge clock);
    check_value("reset_instr", 64'(instruction_o), 64'd0);
    check_value("reset_fwd", {operator_o, operand_a_o, operand_b_o[23:0]}, 64'd0);
    check_value("reset_wr", {26'd0, register_write_enable_o, register_write_address_o, register_write_data_o}, 64'd0);
    check_value("reset_hilo", {register_hi_write_data_o, register_lo_write_data_o}, 64'd0);
    check_value("reset_ctrl", {61'd0, register_hi_write_enable_o, register_lo_write_enable_o, stall_request}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_value("addu_after_reset", 64'(register_write_data_o), 64'h8000_0000);
    check_value("addu_stall", 64'(stall_request), 64'd0);
    check_value("addu_passthru", {register_write_enable_o, register_write_address_o, instruction_o}, {26'd0, 1'b1, 5'd9, 32'h1234_5678});
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (stall_request || register_hi_write_enable_o || register_lo_write_enable_o) flag = 1'b1;
    end
    check_value("reset_aborts_div", 64'(flag), 64'd0);

    // Single-cycle ALU vectors.
    foreach (alu_vecs[i]) begin
      @(posedge clock); #1;
      drive(alu_vecs[i].op, alu_vecs[i].a, alu_vecs[i].b, alu_vecs[i].sa);
      @(negedge clock);
      check_value(alu_vecs[i].tag, 64'(register_write_data_o), 64'(alu_vecs[i].exp));
    end

    @(posedge clock); #1;
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 5'd0);
    @(negedge clock);
    check_value("mthi", {29'd0, register_write_enable_o, register_hi_write_enable_o, register_lo_write_enable_o, register_hi_write_data_o}, {29'd0, 3'b010, 32'hDEAD_BEEF});

    @(posedge clock); #1;
    drive(OP_MTLO, 32'h0BAD_F00D, 32'd0, 5'd0);
    @(negedge clock);
    check_value("mtlo", {29'd0, register_write_enable_o, register_hi_write_enable_o, register_lo_write_enable_o, register_lo_write_data_o}, {29'd0, 3'b001, 32'h0BAD_F00D});

    @(posedge clock); #1;
    drive(OP_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0);
    @(negedge clock);
    check_value("mult_hilo", {register_hi_write_data_o, register_lo_write_data_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    check_value("mult_ctrl", {61'd0, register_hi_write_enable_o, register_lo_write_enable_o, stall_request}, 64'd6);

    @(posedge clock); #1;
    drive(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5'd0);
    @(negedge clock);
    check_value("multu_hilo", {register_hi_write_data_o, register_lo_write_data_o}, 64'h0000_0002_FFFF_FFFA);

    @(posedge clock); #1;
    drive(OP_LW, 32'h0000_1000, 32'hCAFE_0001, 5'd0);
    @(negedge clock);
    check_value("lw", {31'd0, register_write_enable_o, register_write_data_o}, 64'h1_0000_0000);
    check_value("lw_fwd", {operand_a_o, operand_b_o}, 64'h0000_1000_CAFE_0001);

    @(posedge clock); #1;
    drive(8'hFF, 32'd1, 32'd2, 5'd0);
    @(negedge clock);
    check_value("unknown_op", {30'd0, register_hi_write_enable_o, register_lo_write_enable_o, register_write_data_o}, 64'd0);
    check_value("unknown_fwd", 64'(operator_o), 64'hFF);

    // Divider.
    run_div("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("divu_by_zero", OP_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5);
    run_div("div_min_neg1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);

    // Cancel on the tenth busy cycle.
    @(posedge clock); #1;
    drive(OP_DIV, 32'd1000, 32'd3, 5'd0);
    flag = 1'b0;
    @(negedge clock);
    if (!stall_request) flag = 1'b1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clock);
      if (!stall_request || register_hi_write_enable_o || register_lo_write_enable_o) flag = 1'b1;
    end
    check_value("cancel_pre_busy", 64'(flag), 64'd0);
    @(posedge clock); #1;
    cancel = 1'b1;
    @(negedge clock);
    check_value("cancel_cycle", {61'd0, register_hi_write_enable_o, register_lo_write_enable_o, stall_request}, 64'd0);
    @(posedge clock); #1;
    cancel     = 1'b0;
    operator_i = OP_NOP;
    flag       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (stall_request || register_hi_write_enable_o || register_lo_write_enable_o) flag = 1'b1;
    end
    check_value("cancel_no_write", 64'(flag), 64'd0);
    run_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks_total);
    $finish;
  end

endmodule
